// File: rtl/slurm16_memory_arbiter_pkg.sv
// Shared definitions for the SLURM16 memory arbiter: FSM encodings,
// default master roles and the read data returned on an aborted transaction.
package slurm16_mem_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE  = 2'd0;
  localparam arb_state_t ARB_ISSUE = 2'd1;
  localparam arb_state_t ARB_DONE  = 2'd2;

  localparam int unsigned MASTER_IFETCH = 0;
  localparam int unsigned MASTER_DATA   = 1;
  localparam int unsigned MASTER_DMA    = 2;

  localparam logic [15:0] ERR_RDATA = 16'hFFFF;

  // One-hot expansion of a master index (up to four masters).
  function automatic logic [3:0] master_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/slurm16_memory_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and external memory.
// slave : the arbiter's view (serves requesters, drives the memory port).
// master: the environment's view (requesters and memory model).
interface slurm16_memory_arbiter_if #(
  parameter int unsigned NUM_MASTERS  = 3,
  parameter int unsigned ADDRESS_BITS = 16,
  parameter int unsigned BITS         = 16
);

  logic [NUM_MASTERS-1:0]              m_req;
  logic [NUM_MASTERS-1:0]              m_lock;
  logic [NUM_MASTERS-1:0]              m_wr;
  logic [NUM_MASTERS*ADDRESS_BITS-1:0] m_addr;
  logic [NUM_MASTERS*BITS-1:0]         m_wdata;
  logic [NUM_MASTERS*2-1:0]            m_wr_mask;
  logic [NUM_MASTERS-1:0]              m_ack;
  logic [NUM_MASTERS-1:0]              m_err;
  logic [BITS-1:0]                     m_rdata;

  logic [ADDRESS_BITS-1:0]             mem_address;
  logic [BITS-1:0]                     mem_out;
  logic                                mem_wr;
  logic [1:0]                          mem_wr_mask;
  logic                                mem_valid;
  logic [BITS-1:0]                     mem_in;
  logic                                mem_success;

  modport slave (
    input  m_req, m_lock, m_wr, m_addr, m_wdata, m_wr_mask, mem_in, mem_success,
    output m_ack, m_err, m_rdata, mem_address, mem_out, mem_wr, mem_wr_mask, mem_valid
  );

  modport master (
    output m_req, m_lock, m_wr, m_addr, m_wdata, m_wr_mask, mem_in, mem_success,
    input  m_ack, m_err, m_rdata, mem_address, mem_out, mem_wr, mem_wr_mask, mem_valid
  );

endinterface

// File: rtl/slurm16_memory_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting index after rr_ptr,
// searching cyclically.
module slurm16_rr_picker
  import slurm16_mem_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [1:0]             rr_ptr_i,
  output logic [1:0]             winner_o,
  output logic                   any_req_o
);

  int unsigned idx;
  logic        found;

  // Scan rr_ptr+1 .. rr_ptr+NUM_MASTERS modulo NUM_MASTERS, keep the first hit.
  always_comb begin
    winner_o  = '0;
    any_req_o = |req_i;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      idx = 32'(rr_ptr_i) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        winner_o = idx[1:0];
      end
    end
  end

endmodule

// File: rtl/slurm16_memory_arbiter.sv
// SLURM16 memory arbiter: serialises one transaction at a time onto the
// external memory port, round-robin between requesters, with a bounded
// burst lock and a per-transaction timeout.
module slurm16_memory_arbiter
  import slurm16_mem_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned ADDRESS_BITS   = 16,
  parameter int unsigned BITS           = 16,
  parameter int unsigned LOCK_MAX       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  slurm16_memory_arbiter_if.slave  bus,
  output logic [1:0]               grant_owner,
  output logic [7:0]               timeout_count
);

  arb_state_t              state_q, state_d;
  logic [1:0]              g_q, g_d;
  logic [1:0]              rr_ptr_q, rr_ptr_d;
  logic [7:0]              lock_cnt_q, lock_cnt_d;
  logic                    lock_pend_q, lock_pend_d;
  logic [7:0]              to_cnt_q, to_cnt_d;
  logic [7:0]              to_total_q, to_total_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [BITS-1:0]         wdata_q, wdata_d;
  logic                    wr_q, wr_d;
  logic [1:0]              mask_q, mask_d;
  logic                    valid_q, valid_d;
  logic [NUM_MASTERS-1:0]  ack_q, ack_d;
  logic [NUM_MASTERS-1:0]  err_q, err_d;
  logic [BITS-1:0]         rdata_q, rdata_d;

  logic [NUM_MASTERS-1:0]  pick_req;
  logic [1:0]              pick_win;
  logic                    pick_any;
  logic                    grant;
  logic                    grant_locked;
  logic [1:0]              grant_idx;

  // In DONE the acked master's request is still its old one, so mask it out.
  always_comb begin
    pick_req = bus.m_req;
    if (state_q == ARB_DONE) pick_req = bus.m_req & ~NUM_MASTERS'(master_onehot(g_q));
  end

  slurm16_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req_i     (pick_req),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (pick_win),
    .any_req_o (pick_any)
  );

  // Next-state logic: arbitration in IDLE/DONE, completion/timeout in ISSUE.
  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    rr_ptr_d     = rr_ptr_q;
    lock_cnt_d   = lock_cnt_q;
    lock_pend_d  = lock_pend_q;
    to_cnt_d     = to_cnt_q;
    to_total_d   = to_total_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    mask_d       = mask_q;
    valid_d      = valid_q;
    ack_d        = '0;
    err_d        = '0;
    rdata_d      = rdata_q;
    grant        = 1'b0;
    grant_locked = 1'b0;
    grant_idx    = pick_win;

    case (state_q)
      ARB_IDLE: begin
        // A pending lock is honoured only in the first cycle after DONE.
        if (lock_pend_q) begin
          lock_pend_d = 1'b0;
          if (bus.m_req[g_q]) begin
            grant        = 1'b1;
            grant_locked = 1'b1;
            grant_idx    = g_q;
          end
        end
        if (!grant && pick_any) begin
          grant     = 1'b1;
          grant_idx = pick_win;
        end
      end

      ARB_ISSUE: begin
        if (bus.mem_success) begin
          state_d     = ARB_DONE;
          valid_d     = 1'b0;
          ack_d[g_q]  = 1'b1;
          rdata_d     = bus.mem_in;
        end else if (to_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ARB_DONE;
          valid_d     = 1'b0;
          ack_d[g_q]  = 1'b1;
          err_d[g_q]  = 1'b1;
          rdata_d     = BITS'(ERR_RDATA);
          if (to_total_q != 8'hFF) to_total_d = to_total_q + 8'd1;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end

      ARB_DONE: begin
        state_d = ARB_IDLE;
        if (bus.m_lock[g_q] && (lock_cnt_q < 8'(LOCK_MAX - 1))) begin
          lock_pend_d = 1'b1;
        end else if (pick_any) begin
          grant     = 1'b1;
          grant_idx = pick_win;
        end
      end

      default: state_d = ARB_IDLE;
    endcase

    if (grant) begin
      state_d  = ARB_ISSUE;
      g_d      = grant_idx;
      addr_d   = bus.m_addr[grant_idx*ADDRESS_BITS +: ADDRESS_BITS];
      wdata_d  = bus.m_wdata[grant_idx*BITS +: BITS];
      wr_d     = bus.m_wr[grant_idx];
      mask_d   = bus.m_wr_mask[grant_idx*2 +: 2];
      valid_d  = 1'b1;
      to_cnt_d = '0;
      if (grant_locked) begin
        lock_cnt_d = lock_cnt_q + 8'd1;
      end else begin
        lock_cnt_d = '0;
        rr_ptr_d   = grant_idx;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RSTb) begin
      state_q     <= ARB_IDLE;
      g_q         <= '0;
      rr_ptr_q    <= 2'(NUM_MASTERS - 1);
      lock_cnt_q  <= '0;
      lock_pend_q <= 1'b0;
      to_cnt_q    <= '0;
      to_total_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      mask_q      <= '0;
      valid_q     <= 1'b0;
      ack_q       <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_cnt_q  <= lock_cnt_d;
      lock_pend_q <= lock_pend_d;
      to_cnt_q    <= to_cnt_d;
      to_total_q  <= to_total_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      mask_q      <= mask_d;
      valid_q     <= valid_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.m_ack       = ack_q;
  assign bus.m_err       = err_q;
  assign bus.m_rdata     = rdata_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_out     = wdata_q;
  assign bus.mem_wr      = wr_q;
  assign bus.mem_wr_mask = mask_q;
  assign bus.mem_valid   = valid_q;
  assign grant_owner     = g_q;
  assign timeout_count   = to_total_q;

endmodule

// File: tb/tb_slurm16_memory_arbiter.sv
// Directed bench for slurm16_memory_arbiter (3 masters, LOCK_MAX 4, TIMEOUT_CYCLES 10).
module tb_slurm16_memory_arbiter;
  import slurm16_mem_pkg::*;

  logic       CLK = 1'b0;
  logic       RSTb;
  logic [1:0] grant_owner;
  logic [7:0] timeout_count;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 CLK = ~CLK;

  slurm16_memory_arbiter_if #(.NUM_MASTERS(3), .ADDRESS_BITS(16), .BITS(16)) bus ();

  slurm16_memory_arbiter #(
    .NUM_MASTERS(3), .ADDRESS_BITS(16), .BITS(16), .LOCK_MAX(4), .TIMEOUT_CYCLES(10)
  ) dut (
    .CLK           (CLK),
    .RSTb          (RSTb),
    .bus           (bus),
    .grant_owner   (grant_owner),
    .timeout_count (timeout_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_req       = '0;
    bus.m_lock      = '0;
    bus.m_wr        = '0;
    bus.m_addr      = '0;
    bus.m_wdata     = '0;
    bus.m_wr_mask   = '0;
    bus.mem_in      = '0;
    bus.mem_success = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RSTb = 1'b1;
    tick();
    tick();
    RSTb = 1'b0;
  endtask

  function automatic int ack_index(input logic [2:0] a);
    case (a)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 7;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int rr_exp [6];
    int lk_exp [6];
    int seq [6];
    int n;
    int ack_cyc;

    rr_exp = '{0, 1, 2, 0, 1, 2};
    lk_exp = '{2, 2, 2, 2, 0, 1};

    // Reset state
    do_reset();
    check_eq("rst_valid", bus.mem_valid, 1'b0);
    check_eq("rst_ack", bus.m_ack, 3'b000);
    check_eq("rst_err", bus.m_err, 3'b000);
    check_eq("rst_owner", grant_owner, 2'd0);
    check_eq("rst_tocount", timeout_count, 8'd0);
    check_eq("rst_addr", bus.mem_address, 16'h0000);

    // Stray mem_success in IDLE is ignored
    bus.mem_success = 1'b1;
    tick();
    check_eq("idle_succ_ack", bus.m_ack, 3'b000);
    check_eq("idle_succ_valid", bus.mem_valid, 1'b0);
    bus.mem_success = 1'b0;

    // Single read from master 1
    do_reset();
    bus.m_req[MASTER_DATA] = 1'b1;
    bus.m_addr[16 +: 16]   = 16'h4062;
    tick();
    check_eq("rd_valid", bus.mem_valid, 1'b1);
    check_eq("rd_addr", bus.mem_address, 16'h4062);
    check_eq("rd_wr", bus.mem_wr, 1'b0);
    check_eq("rd_owner", grant_owner, 2'd1);
    tick();
    tick();
    tick();
    check_eq("rd_wait_valid", bus.mem_valid, 1'b1);
    check_eq("rd_wait_wr", bus.mem_wr, 1'b0);
    check_eq("rd_wait_ack", bus.m_ack, 3'b000);
    bus.mem_in      = 16'hBEEF;
    bus.mem_success = 1'b1;
    tick();
    check_eq("rd_ack", bus.m_ack, 3'b010);
    check_eq("rd_data", bus.m_rdata, 16'hBEEF);
    check_eq("rd_err", bus.m_err, 3'b000);
    check_eq("rd_valid_drop", bus.mem_valid, 1'b0);
    bus.m_req       = '0;
    bus.mem_success = 1'b0;
    tick();
    check_eq("rd_ack_pulse", bus.m_ack, 3'b000);

    // Round-robin with all masters requesting and immediate success
    do_reset();
    bus.m_req       = 3'b111;
    bus.mem_success = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if ((c % 2) == 0) begin
        check_eq($sformatf("rr_ack_%0d", c), 32'(ack_index(bus.m_ack)), 32'(rr_exp[c/2 - 1]));
      end else begin
        check_eq($sformatf("rr_gap_%0d", c), {bus.mem_valid, bus.m_ack}, 4'b1000);
      end
    end
    bus.m_req       = '0;
    bus.mem_success = 1'b0;
    tick();

    // Lock burst by master 2
    do_reset();
    bus.m_req[MASTER_DMA]  = 1'b1;
    bus.m_lock[MASTER_DMA] = 1'b1;
    bus.mem_success        = 1'b1;
    tick();
    check_eq("lk_first_owner", grant_owner, 2'd2);
    bus.m_req = 3'b111;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      tick();
      if (bus.m_ack != 3'b000) begin
        seq[n] = ack_index(bus.m_ack);
        n++;
      end
    end
    check_eq("lk_count", 32'(n), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < n) check_eq($sformatf("lk_seq_%0d", i), 32'(seq[i]), 32'(lk_exp[i]));
    end
    clear_inputs();
    tick();
    tick();

    // Timeout on a write from master 0
    do_reset();
    bus.m_req[MASTER_IFETCH] = 1'b1;
    bus.m_wr[MASTER_IFETCH]  = 1'b1;
    bus.m_addr[0 +: 16]      = 16'h1234;
    bus.m_wdata[0 +: 16]     = 16'h5555;
    bus.m_wr_mask[0 +: 2]    = 2'b11;
    ack_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.m_ack != 3'b000) begin
        ack_cyc = c;
        break;
      end
    end
    check_eq("to_ack_cycle", 32'(ack_cyc), 32'd11);
    check_eq("to_ack", bus.m_ack, 3'b001);
    check_eq("to_err", bus.m_err, 3'b001);
    check_eq("to_rdata", bus.m_rdata, 16'hFFFF);
    check_eq("to_count", timeout_count, 8'd1);
    bus.m_req = '0;
    tick();
    check_eq("to_err_pulse", bus.m_err, 3'b000);

    // Success on the 10th ISSUE cycle beats the timeout
    bus.m_req[MASTER_IFETCH] = 1'b1;
    tick();
    for (int c = 0; c < 9; c++) tick();
    check_eq("to10_no_ack_yet", bus.m_ack, 3'b000);
    bus.mem_in      = 16'h1357;
    bus.mem_success = 1'b1;
    tick();
    check_eq("to10_ack", bus.m_ack, 3'b001);
    check_eq("to10_err", bus.m_err, 3'b000);
    check_eq("to10_rdata", bus.m_rdata, 16'h1357);
    check_eq("to10_count", timeout_count, 8'd1);
    clear_inputs();
    tick();

    // Write mask passthrough, inputs changed after grant
    do_reset();
    bus.m_req[MASTER_DATA] = 1'b1;
    bus.m_wr[MASTER_DATA]  = 1'b1;
    bus.m_addr[16 +: 16]   = 16'h3838;
    bus.m_wdata[16 +: 16]  = 16'h00AB;
    bus.m_wr_mask[2 +: 2]  = 2'b01;
    tick();
    bus.m_wr[MASTER_DATA]  = 1'b0;
    bus.m_addr[16 +: 16]   = 16'hFFFF;
    bus.m_wdata[16 +: 16]  = 16'h0000;
    bus.m_wr_mask[2 +: 2]  = 2'b10;
    for (int c = 0; c < 3; c++) begin
      check_eq($sformatf("wr_stable_%0d", c),
               {bus.mem_valid, bus.mem_wr, bus.mem_wr_mask, bus.mem_address, bus.mem_out[11:0]},
               {1'b1, 1'b1, 2'b01, 16'h3838, 12'h0AB});
      tick();
    end
    bus.mem_success = 1'b1;
    tick();
    check_eq("wr_ack", bus.m_ack, 3'b010);
    clear_inputs();
    tick();

    // Reset in the middle of ISSUE
    do_reset();
    bus.m_req[MASTER_DMA] = 1'b1;
    tick();
    check_eq("mid_valid", bus.mem_valid, 1'b1);
    RSTb = 1'b1;
    tick();
    check_eq("mid_rst_valid", bus.mem_valid, 1'b0);
    check_eq("mid_rst_ack", bus.m_ack, 3'b000);
    RSTb            = 1'b0;
    bus.m_req       = 3'b111;
    bus.mem_success = 1'b1;
    tick();
    check_eq("mid_first_owner", grant_owner, 2'd0);
    check_eq("mid_first_valid", bus.mem_valid, 1'b1);
    clear_inputs();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/slurm16_memory_arbiter.md
Name: slurm16_memory_arbiter

Overview:
Shares the single external SLURM16 memory bus between NUM_MASTERS requesters. Default wiring: master 0 is CPU instruction fetch, master 1 is CPU load/store, master 2 is the DMA/graphics engine. It sits between the requesters and the external memory port. It serialises one transaction at a time using round-robin arbitration, with an optional bounded burst lock and a per-transaction timeout.

Parameters:
NUM_MASTERS, 3, number of requesters (2..4)
ADDRESS_BITS, 16, memory address width
BITS, 16, data width
LOCK_MAX, 4, maximum consecutive grants one master may hold via lock
TIMEOUT_CYCLES, 255, cycles allowed in ISSUE before abort (1..255)

Ports:
CLK  in  1  system clock
RSTb  in  1  reset, synchronous, active-high
m_req  in  NUM_MASTERS  per-master request; held until m_ack
m_lock  in  NUM_MASTERS  request to keep grant for following transaction
m_wr  in  NUM_MASTERS  1 = write, 0 = read
m_addr  in  NUM_MASTERS*ADDRESS_BITS  packed addresses; master i at [i*16 +: 16]
m_wdata  in  NUM_MASTERS*BITS  packed write data
m_wr_mask  in  NUM_MASTERS*2  packed byte-lane masks
m_ack  out  NUM_MASTERS  one-cycle completion pulse, one-hot
m_err  out  NUM_MASTERS  one-cycle pulse coincident with m_ack on timeout
m_rdata  out  BITS  read data, valid while m_ack is high
mem_address  out  ADDRESS_BITS  to memory
mem_out  out  BITS  write data to memory
mem_wr  out  1  write strobe, qualified by mem_valid
mem_wr_mask  out  2  byte lanes
mem_valid  out  1  transaction request to memory
mem_in  in  BITS  read data from memory
mem_success  in  1  memory completes the current transaction this cycle
grant_owner  out  2  index of last/current granted master (debug)
timeout_count  out  8  saturating count of aborted transactions (debug)

Behaviour:
- Reset values: state IDLE; all outputs 0; rr_ptr = NUM_MASTERS-1, so master 0 wins first; lock_cnt 0; timeout_count 0.
- States:
  - IDLE: no transaction outstanding.
  - ISSUE: mem_valid = 1, waiting for mem_success.
  - DONE: ack cycle.
- IDLE -> ISSUE when any m_req is set. Winner = first requesting index after rr_ptr, searching cyclically. The winner's addr, wdata, wr and mask are registered into the mem_* outputs. mem_valid rises the cycle after the request is sampled.
- Outputs are stable for the whole of ISSUE. Requesters may change inputs after grant without effect.
- ISSUE -> DONE on mem_success. mem_in is latched into m_rdata. mem_valid drops in the same transition.
- DONE: m_ack[g] = 1 for exactly one cycle. Then return to IDLE, or stay in ISSUE per the back-to-back rule below.
- Minimum transaction with mem_success on the first ISSUE cycle:
  - request sampled at t;
  - mem_valid high at t+1;
  - success at t+1;
  - m_ack at t+2.
- Back-to-back: in DONE, if any other m_req is pending (excluding the master being acked), arbitration occurs in DONE itself and ISSUE re-enters at the next cycle with no IDLE bubble. The acked master's m_req in DONE is ignored, since it is still its old request.
- Lock:
  - If m_lock[g] is high in DONE and lock_cnt < LOCK_MAX-1, the next grant goes to g: the first cycle after DONE in which m_req[g] is set wins regardless of other requesters. lock_cnt increments.
  - If m_req[g] is not high within 1 cycle after DONE, the lock is released.
  - lock_cnt resets to 0 whenever a non-locked grant occurs.
  - rr_ptr updates to g only on non-locked grants.
- Timeout:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle.
  - At TIMEOUT_CYCLES without mem_success, go to DONE with m_err[g] = 1 and m_rdata = 16'hFFFF. timeout_count increments, saturating at 255.
  - A mem_success arriving in the same cycle as the timeout wins: normal completion, no error.
- mem_success while not in ISSUE is ignored.
- Withdrawing m_req during ISSUE has no effect: the transaction completes and the ack is still pulsed.
- Reset mid-ISSUE: mem_valid drops on the next edge, no ack is issued, and the memory side must tolerate the abandoned request.
- NUM_MASTERS < 4: unused grant_owner codes are never produced.

Decomposition:
- Shared package slurm16_mem_pkg:
  - state encoding (ARB_IDLE = 0, ARB_ISSUE = 1, ARB_DONE = 2);
  - master index constants MASTER_IFETCH = 0, MASTER_DATA = 1, MASTER_DMA = 2;
  - ERR_RDATA = 16'hFFFF.
- One sub-module: slurm16_rr_picker, purely combinational. Inputs: req vector and rr_ptr. Outputs: winner index and any_req. Used in both IDLE and DONE.

Test Plan:
- Single read: master 1 requests addr 16'h4062, memory returns 16'hBEEF with mem_success 3 cycles after mem_valid -> m_ack[1] pulses 1 cycle, m_rdata = 16'hBEEF, mem_wr = 0 throughout.
- Round-robin fairness: all 3 masters request continuously, mem_success on the first ISSUE cycle -> grant order 0,1,2,0,1,2 with no IDLE cycles between transactions.
- Lock burst: master 2 holds m_lock and m_req while masters 0 and 1 also request, LOCK_MAX = 4 -> grants 2,2,2,2 then 0, then 1.
- Timeout: TIMEOUT_CYCLES = 10, mem_success never asserted for a write from master 0 -> m_ack[0] and m_err[0] after 10 ISSUE cycles, m_rdata = 16'hFFFF, timeout_count = 1. Repeat with mem_success on cycle 10 -> no error.
- Write mask passthrough: master 1 writes 16'h00AB, mask 2'b01, addr 16'h3838 -> mem_wr = 1, mem_wr_mask = 2'b01, mem_out = 16'h00AB held stable until mem_success.
- Reset mid-operation: assert RSTb during ISSUE -> mem_valid = 0 and all acks 0 next cycle; after release, master 0 is granted first.
